dm_load_wb: RTL and testbench
=============================

Name: dm_load_wb

Overview:
- M/W pipeline boundary that sits directly downstream of the data memory.
- Captures M-stage control at the clock edge, then consumes the BRAM read word one cycle later. The BRAM read is synchronous, so the word arrives in the W cycle.
- Selects and sign/zero-extends the loaded byte or halfword. Flags misaligned loads.
- Produces the register-file writeback triple and holds the loaded word stable across stalls.

Parameters:
- RESET_PC, 32'h0000_3000, value of W_PC after reset or flush.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  freeze W register; upstream M stage is frozen in the same cycle
- Flush  in  1  load a bubble into W at the next edge
- M_Valid  in  1  M-stage instruction is real (not a bubble)
- M_LoadOp  in  3  000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; others treated as none
- M_Addr  in  32  effective address, also driven to the dm address input
- M_AluRes  in  32  non-load result
- M_RegWe  in  1  instruction writes GPR
- M_WAddr  in  5  destination GPR
- M_PC  in  32  instruction PC
- Dm_Dout  in  32  dm read word; valid in the cycle after M_Addr was presented
- W_Valid  out  1  W holds a real instruction
- W_RegWe  out  1  GPR write enable
- W_WAddr  out  5  GPR index
- W_WData  out  32  writeback data
- W_PC  out  32  PC of W instruction
- W_AdEL  out  1  misaligned-load exception flag

Behaviour:
- Reset (async, immediate), registered state:
  - W_Valid=0, LoadOp=none, AluRes=0, WAddr=0, RegWe=0, PC=RESET_PC, Addr[1:0]=0, hold flag=0, hold data=0.
- Reset outputs: W_RegWe=0, W_WData=0, W_AdEL=0.
- Edge priority: Reset > Stall > Flush > normal capture.
- Stall=1 with Flush=1: the stall wins; the flush is ignored in that cycle and upstream reasserts it.
- Normal capture: all M_* fields register. LoadOp is forced to none when M_Valid=0.
- Flush: registers take their reset values, except hold flag is cleared.
- Latency: one edge from M to W. W_WData is combinational from the W registers and the selected read word. There is no extra cycle.
- Read-word selection:
  - RD = hold flag ? hold data : Dm_Dout.
  - On the first Stall cycle with a load in W, hold data <= Dm_Dout and hold flag <= 1.
  - Hold flag clears on the first non-stalled edge.
  - A stalled load therefore delivers the word sampled in its first W cycle, even if the dm output changes.
- Byte lanes are little-endian; the byte index b = Addr[1:0] selects RD[8b+7:8b].
  - lb/lbu: selected byte, sign- or zero-extended to 32.
  - lh/lhu: Addr[1]=0 -> RD[15:0], Addr[1]=1 -> RD[31:16], sign- or zero-extended.
  - lw: RD.
  - none: AluRes.
- Misalignment: lw with Addr[1:0]!=0, or lh/lhu with Addr[0]=1, sets W_AdEL=1. In that case W_RegWe=0 and W_WData=0.
- W_RegWe = W_Valid & RegWe & (WAddr!=0) & !W_AdEL.
- W_AdEL is 0 whenever W_Valid=0.
- Reset asserted mid-stall clears the hold flag and the hold data.

Test Plan:
- Reset released, no stimulus -> W_Valid=0, W_RegWe=0, W_WData=0, W_PC=32'h3000.
- lb at Addr=0x...0003, Dm_Dout=0x80_12_34_56 in the next cycle -> W_WData=0xFFFFFF80; lbu same -> 0x00000080; W_RegWe=1 with WAddr=8.
- lh at Addr ending 2, Dm_Dout=0x9ABC_1234 -> 0xFFFF9ABC; lhu -> 0x00009ABC; lh at Addr ending 1 -> W_AdEL=1, W_RegWe=0, W_WData=0.
- lw to WAddr=0, Dm_Dout=0xDEADBEEF -> W_WData=0xDEADBEEF, W_RegWe=0; non-load, AluRes=0x1234 to WAddr=3 -> W_WData=0x1234, W_RegWe=1.
- lw in W, Stall held 3 cycles while Dm_Dout changes 0x11111111 -> 0x22222222 after the first cycle -> W_WData stays 0x11111111 throughout; W fields unchanged; after release the next instruction captures normally.
- Flush on a valid lw -> next cycle W_Valid=0, W_RegWe=0; Stall+Flush together -> W contents unchanged; Reset pulsed mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dm_load_wb.sv
// M/W pipeline register downstream of a synchronous-read data memory.
// Aligns and extends loaded data, flags misaligned loads, and holds the read word across stalls.
module dm_load_wb #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        M_Valid,
    input  logic [2:0]  M_LoadOp,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_AluRes,
    input  logic        M_RegWe,
    input  logic [4:0]  M_WAddr,
    input  logic [31:0] M_PC,
    input  logic [31:0] Dm_Dout,
    output logic        W_Valid,
    output logic        W_RegWe,
    output logic [4:0]  W_WAddr,
    output logic [31:0] W_WData,
    output logic [31:0] W_PC,
    output logic        W_AdEL
);

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_W    = 3'b001,
        LD_H    = 3'b010,
        LD_HU   = 3'b011,
        LD_B    = 3'b100,
        LD_BU   = 3'b101
    } load_op_e;

    logic        valid_q,     valid_d;
    load_op_e    load_op_q,   load_op_d;
    logic [31:0] alu_res_q,   alu_res_d;
    logic [4:0]  waddr_q,     waddr_d;
    logic        reg_we_q,    reg_we_d;
    logic [31:0] pc_q,        pc_d;
    logic [1:0]  addr_lo_q,   addr_lo_d;
    logic        hold_q,      hold_d;
    logic [31:0] hold_data_q, hold_data_d;

    load_op_e    m_op;
    logic [31:0] rd;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic        ad_el;

    // Unknown encodings and bubbles both collapse to "no load".
    always_comb begin
        case (M_LoadOp)
            3'b001:  m_op = LD_W;
            3'b010:  m_op = LD_H;
            3'b011:  m_op = LD_HU;
            3'b100:  m_op = LD_B;
            3'b101:  m_op = LD_BU;
            default: m_op = LD_NONE;
        endcase
        if (!M_Valid) m_op = LD_NONE;
    end

    always_comb begin
        // NOTE: every _d starts at its _q value so no path leaves a latch behind.
        valid_d     = valid_q;
        load_op_d   = load_op_q;
        alu_res_d   = alu_res_q;
        waddr_d     = waddr_q;
        reg_we_d    = reg_we_q;
        pc_d        = pc_q;
        addr_lo_d   = addr_lo_q;
        hold_d      = hold_q;
        hold_data_d = hold_data_q;

        if (Stall) begin
            // The dm output is only guaranteed in the load's first W cycle; snapshot it once.
            if (!hold_q && valid_q && load_op_q != LD_NONE) begin
                hold_d      = 1'b1;
                hold_data_d = Dm_Dout;
            end
        end else if (Flush) begin
            valid_d     = 1'b0;
            load_op_d   = LD_NONE;
            alu_res_d   = '0;
            waddr_d     = '0;
            reg_we_d    = 1'b0;
            pc_d        = RESET_PC;
            addr_lo_d   = '0;
            hold_d      = 1'b0;
            hold_data_d = '0;
        end else begin
            valid_d   = M_Valid;
            load_op_d = m_op;
            alu_res_d = M_AluRes;
            waddr_d   = M_WAddr;
            reg_we_d  = M_RegWe;
            pc_d      = M_PC;
            addr_lo_d = M_Addr[1:0];
            hold_d    = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q     <= 1'b0;
            load_op_q   <= LD_NONE;
            alu_res_q   <= '0;
            waddr_q     <= '0;
            reg_we_q    <= 1'b0;
            pc_q        <= RESET_PC;
            addr_lo_q   <= '0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of its peers.
            valid_q     <= valid_d;
            load_op_q   <= load_op_d;
            alu_res_q   <= alu_res_d;
            waddr_q     <= waddr_d;
            reg_we_q    <= reg_we_d;
            pc_q        <= pc_d;
            addr_lo_q   <= addr_lo_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign rd      = hold_q ? hold_data_q : Dm_Dout;
    assign rd_half = addr_lo_q[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        case (addr_lo_q)
            2'd0:    rd_byte = rd[7:0];
            2'd1:    rd_byte = rd[15:8];
            2'd2:    rd_byte = rd[23:16];
            default: rd_byte = rd[31:24];
        endcase
    end

    always_comb begin
        case (load_op_q)
            LD_W:    load_data = rd;
            LD_H:    load_data = {{16{rd_half[15]}}, rd_half};
            LD_HU:   load_data = {16'h0000, rd_half};
            LD_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            LD_BU:   load_data = {24'h000000, rd_byte};
            default: load_data = alu_res_q;
        endcase
    end

    always_comb begin
        ad_el = 1'b0;
        if (valid_q) begin
            case (load_op_q)
                LD_W:        ad_el = (addr_lo_q != 2'd0);
                LD_H, LD_HU: ad_el = addr_lo_q[0];
                default:     ad_el = 1'b0;
            endcase
        end
    end

    assign W_Valid = valid_q;
    assign W_WAddr = waddr_q;
    assign W_PC    = pc_q;
    assign W_AdEL  = ad_el;
    assign W_WData = ad_el ? 32'h0000_0000 : load_data;
    assign W_RegWe = valid_q & reg_we_q & (waddr_q != 5'd0) & ~ad_el;

endmodule

// File: tb/tb_dm_load_wb.sv
// Directed bench for dm_load_wb: load extension, misalignment, stall hold, flush and reset.
module tb_dm_load_wb;

    logic        Clk, Reset, Stall, Flush;
    logic        M_Valid, M_RegWe;
    logic [2:0]  M_LoadOp;
    logic [31:0] M_Addr, M_AluRes, M_PC, Dm_Dout;
    logic [4:0]  M_WAddr;
    logic        W_Valid, W_RegWe, W_AdEL;
    logic [4:0]  W_WAddr;
    logic [31:0] W_WData, W_PC;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_NONE = 3'b000, OP_LW = 3'b001, OP_LH = 3'b010,
                           OP_LHU = 3'b011, OP_LB = 3'b100, OP_LBU = 3'b101;

    dm_load_wb #(.RESET_PC(32'h0000_3000)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .M_Valid(M_Valid), .M_LoadOp(M_LoadOp), .M_Addr(M_Addr), .M_AluRes(M_AluRes),
        .M_RegWe(M_RegWe), .M_WAddr(M_WAddr), .M_PC(M_PC), .Dm_Dout(Dm_Dout),
        .W_Valid(W_Valid), .W_RegWe(W_RegWe), .W_WAddr(W_WAddr), .W_WData(W_WData),
        .W_PC(W_PC), .W_AdEL(W_AdEL)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic drive_m(input logic v, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] alu, input logic we, input logic [4:0] wa,
                           input logic [31:0] pc);
        M_Valid = v; M_LoadOp = op; M_Addr = addr; M_AluRes = alu;
        M_RegWe = we; M_WAddr = wa; M_PC = pc;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Dm_Dout = 32'h0;
        drive_m(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #12 Reset = 1'b0;
        #1;
        checks++; if (W_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", W_Valid); end
        checks++; if (W_RegWe !== 1'b0) begin errors++; $display("FAIL reset_regwe got %b want 0", W_RegWe); end
        checks++; if (W_WData !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", W_WData); end
        checks++; if (W_PC !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h want 00003000", W_PC); end
        checks++; if (W_AdEL !== 1'b0) begin errors++; $display("FAIL reset_adel got %b want 0", W_AdEL); end
    endtask

    task automatic test_byte_loads();
        drive_m(1'b1, OP_LB, 32'h0000_1003, 32'h0, 1'b1, 5'd8, 32'h100);
        step(); Dm_Dout = 32'h8012_3456; #1;
        checks++; if (W_WData !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_b3 got %h want ffffff80", W_WData); end
        checks++; if (W_RegWe !== 1'b1) begin errors++; $display("FAIL lb_regwe got %b want 1", W_RegWe); end
        checks++; if (W_WAddr !== 5'd8) begin errors++; $display("FAIL lb_waddr got %0d want 8", W_WAddr); end
        checks++; if (W_PC !== 32'h100) begin errors++; $display("FAIL lb_pc got %h want 00000100", W_PC); end
        drive_m(1'b1, OP_LBU, 32'h0000_1003, 32'h0, 1'b1, 5'd8, 32'h104);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_0080) begin errors++; $display("FAIL lbu_b3 got %h want 00000080", W_WData); end
        drive_m(1'b1, OP_LB, 32'h0000_1000, 32'h0, 1'b1, 5'd8, 32'h108);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_0056) begin errors++; $display("FAIL lb_b0 got %h want 00000056", W_WData); end
        drive_m(1'b1, OP_LBU, 32'h0000_1001, 32'h0, 1'b1, 5'd8, 32'h10C);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_0034) begin errors++; $display("FAIL lbu_b1 got %h want 00000034", W_WData); end
        drive_m(1'b1, OP_LB, 32'h0000_1002, 32'h0, 1'b1, 5'd8, 32'h110);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_0012) begin errors++; $display("FAIL lb_b2 got %h want 00000012", W_WData); end
    endtask

    task automatic test_half_loads();
        drive_m(1'b1, OP_LH, 32'h0000_2002, 32'h0, 1'b1, 5'd9, 32'h200);
        step(); Dm_Dout = 32'h9ABC_1234; #1;
        checks++; if (W_WData !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_hi got %h want ffff9abc", W_WData); end
        drive_m(1'b1, OP_LHU, 32'h0000_2002, 32'h0, 1'b1, 5'd9, 32'h204);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_hi got %h want 00009abc", W_WData); end
        drive_m(1'b1, OP_LH, 32'h0000_2000, 32'h0, 1'b1, 5'd9, 32'h208);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_1234) begin errors++; $display("FAIL lh_lo got %h want 00001234", W_WData); end
        drive_m(1'b1, OP_LH, 32'h0000_2001, 32'h0, 1'b1, 5'd9, 32'h20C);
        step(); #1;
        checks++; if (W_AdEL !== 1'b1) begin errors++; $display("FAIL lh_mis_adel got %b want 1", W_AdEL); end
        checks++; if (W_RegWe !== 1'b0) begin errors++; $display("FAIL lh_mis_regwe got %b want 0", W_RegWe); end
        checks++; if (W_WData !== 32'h0) begin errors++; $display("FAIL lh_mis_wdata got %h want 0", W_WData); end
        drive_m(1'b1, OP_LHU, 32'h0000_2002, 32'h0, 1'b1, 5'd9, 32'h210);
        step(); #1;
        checks++; if (W_AdEL !== 1'b0) begin errors++; $display("FAIL lhu_al_adel got %b want 0", W_AdEL); end
        drive_m(1'b1, OP_LW, 32'h0000_2002, 32'h0, 1'b1, 5'd9, 32'h214);
        step(); #1;
        checks++; if (W_AdEL !== 1'b1) begin errors++; $display("FAIL lw_mis_adel got %b want 1", W_AdEL); end
        checks++; if (W_WData !== 32'h0) begin errors++; $display("FAIL lw_mis_wdata got %h want 0", W_WData); end
    endtask

    task automatic test_word_and_alu();
        drive_m(1'b1, OP_LW, 32'h0000_3000, 32'h0, 1'b1, 5'd0, 32'h300);
        step(); Dm_Dout = 32'hDEAD_BEEF; #1;
        checks++; if (W_WData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_r0_wdata got %h want deadbeef", W_WData); end
        checks++; if (W_RegWe !== 1'b0) begin errors++; $display("FAIL lw_r0_regwe got %b want 0", W_RegWe); end
        drive_m(1'b1, OP_NONE, 32'h0000_0001, 32'h0000_1234, 1'b1, 5'd3, 32'h304);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata got %h want 00001234", W_WData); end
        checks++; if (W_RegWe !== 1'b1) begin errors++; $display("FAIL alu_regwe got %b want 1", W_RegWe); end
        checks++; if (W_WAddr !== 5'd3) begin errors++; $display("FAIL alu_waddr got %0d want 3", W_WAddr); end
        drive_m(1'b1, 3'b111, 32'h0000_0003, 32'h0000_5678, 1'b1, 5'd4, 32'h308);
        step(); #1;
        checks++; if (W_WData !== 32'h0000_5678) begin errors++; $display("FAIL badop_wdata got %h want 00005678", W_WData); end
        checks++; if (W_AdEL !== 1'b0) begin errors++; $display("FAIL badop_adel got %b want 0", W_AdEL); end
        drive_m(1'b0, OP_LW, 32'h0000_0003, 32'h0000_9999, 1'b1, 5'd4, 32'h30C);
        step(); #1;
        checks++; if (W_Valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b want 0", W_Valid); end
        checks++; if (W_AdEL !== 1'b0) begin errors++; $display("FAIL bubble_adel got %b want 0", W_AdEL); end
        checks++; if (W_RegWe !== 1'b0) begin errors++; $display("FAIL bubble_regwe got %b want 0", W_RegWe); end
        checks++; if (W_WData !== 32'h0000_9999) begin errors++; $display("FAIL bubble_wdata got %h want 00009999", W_WData); end
    endtask

    task automatic test_stall_hold();
        drive_m(1'b1, OP_LW, 32'h0000_4000, 32'h0, 1'b1, 5'd5, 32'h400);
        step(); Dm_Dout = 32'h1111_1111; #1;
        checks++; if (W_WData !== 32'h1111_1111) begin errors++; $display("FAIL stall_pre got %h want 11111111", W_WData); end
        Stall = 1'b1;
        drive_m(1'b1, OP_NONE, 32'h0, 32'h0000_00AA, 1'b1, 5'd6, 32'h404);
        for (int i = 0; i < 3; i++) begin
            step(); Dm_Dout = 32'h2222_2222; #1;
            checks++; if (W_WData !== 32'h1111_1111) begin errors++; $display("FAIL stall_hold%0d got %h want 11111111", i, W_WData); end
            checks++; if (W_PC !== 32'h400 || W_WAddr !== 5'd5 || W_RegWe !== 1'b1) begin
                errors++; $display("FAIL stall_fields%0d pc %h waddr %0d regwe %b want 400 5 1", i, W_PC, W_WAddr, W_RegWe);
            end
        end
        Stall = 1'b0;
        step(); #1;
        checks++; if (W_PC !== 32'h404 || W_WData !== 32'h0000_00AA) begin
            errors++; $display("FAIL stall_release pc %h wdata %h want 404 000000aa", W_PC, W_WData);
        end
        drive_m(1'b1, OP_LW, 32'h0000_4004, 32'h0, 1'b1, 5'd7, 32'h408);
        step(); Dm_Dout = 32'h3333_3333; #1;
        checks++; if (W_WData !== 32'h3333_3333) begin errors++; $display("FAIL stall_after got %h want 33333333", W_WData); end
    endtask

    task automatic test_flush();
        drive_m(1'b1, OP_LW, 32'h0000_5000, 32'h0, 1'b1, 5'd10, 32'h500);
        Flush = 1'b1;
        step(); Flush = 1'b0; Dm_Dout = 32'h4444_4444; #1;
        checks++; if (W_Valid !== 1'b0 || W_RegWe !== 1'b0) begin
            errors++; $display("FAIL flush_valid valid %b regwe %b want 0 0", W_Valid, W_RegWe);
        end
        checks++; if (W_PC !== 32'h0000_3000 || W_WData !== 32'h0) begin
            errors++; $display("FAIL flush_regs pc %h wdata %h want 00003000 0", W_PC, W_WData);
        end
        drive_m(1'b1, OP_NONE, 32'h0, 32'h0000_0055, 1'b1, 5'd7, 32'h600);
        step(); #1;
        Stall = 1'b1; Flush = 1'b1;
        drive_m(1'b1, OP_NONE, 32'h0, 32'h0000_0066, 1'b1, 5'd8, 32'h604);
        step(); Stall = 1'b0; Flush = 1'b0; #1;
        checks++; if (W_Valid !== 1'b1 || W_PC !== 32'h600 || W_WData !== 32'h55 || W_WAddr !== 5'd7) begin
            errors++; $display("FAIL stall_flush valid %b pc %h wdata %h waddr %0d want 1 600 55 7", W_Valid, W_PC, W_WData, W_WAddr);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_m(1'b1, OP_LW, 32'h0000_7000, 32'h0, 1'b1, 5'd11, 32'h700);
        step(); Dm_Dout = 32'hAAAA_5555;
        Stall = 1'b1;
        step(); Dm_Dout = 32'hBBBB_BBBB; #2;
        checks++; if (W_WData !== 32'hAAAA_5555) begin errors++; $display("FAIL rst_stall_pre got %h want aaaa5555", W_WData); end
        Reset = 1'b1; #1;
        checks++; if (W_Valid !== 1'b0 || W_RegWe !== 1'b0 || W_WData !== 32'h0 || W_AdEL !== 1'b0 || W_PC !== 32'h0000_3000) begin
            errors++; $display("FAIL rst_async valid %b regwe %b wdata %h adel %b pc %h", W_Valid, W_RegWe, W_WData, W_AdEL, W_PC);
        end
        step(); Reset = 1'b0; Stall = 1'b0;
        drive_m(1'b1, OP_LW, 32'h0000_7004, 32'h0, 1'b1, 5'd12, 32'h704);
        step(); Dm_Dout = 32'h7777_7777; #1;
        checks++; if (W_WData !== 32'h7777_7777) begin errors++; $display("FAIL rst_hold_clr got %h want 77777777", W_WData); end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_half_loads();
        test_word_and_alu();
        test_stall_hold();
        test_flush();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
